// File: rtl/interrupt_pkg.sv
// interrupt_pkg: shared FSM encoding, PC width and default vector layout for the interrupt controller.
package interrupt_pkg;
  localparam int PC_W = 11;
  localparam logic [PC_W-1:0] VECTOR_BASE_DEF = 11'h780;
  localparam int VECTOR_STRIDE_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, ACTIVE = 2'd2} state_e;
endpackage

// File: rtl/irq_edge_detect.sv
// irq_edge_detect: one-line rising-edge detector; IRQ_SYNC_EN inserts a 2-flop synchronizer
// in front of the edge detect for asynchronous pins.
module irq_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  output logic rise_o
);
  logic irq_s;
  logic irq_d_q;
`ifdef IRQ_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], irq_i};
  assign irq_s = sync_q[1];
`else
  assign irq_s = irq_i;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) irq_d_q <= 1'b0;
    else        irq_d_q <= irq_s;
  assign rise_o = irq_s & ~irq_d_q;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches IRQ rises, masks and prioritises them, and hijacks fetch for a
// one-cycle ENTRY (squash, push PC, jump to vector) until CIS. IRQ_SYNC_EN adds input synchronizers.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int              NUM_IRQ       = 4,
  parameter logic [PC_W-1:0] VECTOR_BASE   = VECTOR_BASE_DEF,
  parameter int              VECTOR_STRIDE = VECTOR_STRIDE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               mask_w_enable_i,
  input  logic [NUM_IRQ-1:0] mask_w_data_i,
  input  logic [PC_W-1:0]    rom_pc_i,
  input  logic               dec_jump_enable_i,
  input  logic               dec_pc_push_enable_i,
  input  logic               interrupt_clear_status_i,
  output logic               int_hold_o,
  output logic               int_jump_enable_o,
  output logic [PC_W-1:0]    int_jump_data_o,
  output logic               int_pc_push_enable_o,
  output logic [PC_W-1:0]    int_pc_push_data_o,
  output logic               int_active_o,
  output logic [2:0]         int_source_o,
  output logic [NUM_IRQ-1:0] pending_o
);
  state_e state_q, state_d;
  logic [NUM_IRQ-1:0] rise, eligible, clr;
  logic [NUM_IRQ-1:0] pending_q, pending_d, mask_q, mask_d;
  logic [2:0] sel, src_q, src_d;
  logic go, entry;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_edge
    irq_edge_detect u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .irq_i  (irq_i[g]),
      .rise_o (rise[g])
    );
  end

  always_comb begin
    eligible = pending_q & mask_q;
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (eligible[i]) sel = 3'(i);
    go = (state_q == IDLE) && |eligible && !dec_jump_enable_i && !dec_pc_push_enable_i;
  end

  always_comb
    state_d = (state_q == ENTRY) ? ACTIVE :
              go ? ENTRY :
              (state_q == ACTIVE && !interrupt_clear_status_i) ? ACTIVE : IDLE;

  // Source is frozen at the IDLE->ENTRY decision so mask/pending changes cannot retarget the entry.
  always_comb begin
    clr = (state_q == ENTRY) ? NUM_IRQ'(1) << src_q : '0;
    pending_d = (pending_q & ~clr) | rise;
    mask_d = mask_w_enable_i ? mask_w_data_i : mask_q;
    src_d = go ? sel : src_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      src_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      src_q     <= src_d;
    end

  always_comb begin
    entry = state_q == ENTRY;
    int_hold_o = entry;
    int_jump_enable_o = entry;
    int_pc_push_enable_o = entry;
    int_jump_data_o = entry ? PC_W'(32'(VECTOR_BASE) + 32'(src_q) * 32'(VECTOR_STRIDE)) : '0;
    int_pc_push_data_o = entry ? rom_pc_i : '0;
    int_active_o = state_q == ACTIVE;
    int_source_o = src_q;
    pending_o = pending_q;
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_interrupt_controller;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] irq, mask_wd;
  logic mask_we, dj, dp, cis;
  logic [10:0] rom_pc;
  logic hold, jen, pen, active;
  logic [10:0] jdata, pdata;
  logic [2:0] src;
  logic [3:0] pend;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .irq_i                    (irq),
    .mask_w_enable_i          (mask_we),
    .mask_w_data_i            (mask_wd),
    .rom_pc_i                 (rom_pc),
    .dec_jump_enable_i        (dj),
    .dec_pc_push_enable_i     (dp),
    .interrupt_clear_status_i (cis),
    .int_hold_o               (hold),
    .int_jump_enable_o        (jen),
    .int_jump_data_o          (jdata),
    .int_pc_push_enable_o     (pen),
    .int_pc_push_data_o       (pdata),
    .int_active_o             (active),
    .int_source_o             (src),
    .pending_o                (pend)
  );

  // Reference model: flags for "entering" and "in service" plus the pending/mask sets.
  logic [3:0] m_pend, m_mask, m_prev;
  logic m_ent, m_serv;
  int m_src;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_pend <= '0; m_mask <= '0; m_prev <= '0; m_ent <= 1'b0; m_serv <= 1'b0; m_src <= 0;
    end else begin : mdl
      logic [3:0] pn;
      int lo;
      pn = m_pend;
      lo = -1;
      for (int s = 3; s >= 0; s--) if (m_pend[s] && m_mask[s]) lo = s;
      if (m_ent) begin
        pn[m_src] = 1'b0;
        m_ent <= 1'b0;
        m_serv <= 1'b1;
      end else if (m_serv) begin
        if (cis) m_serv <= 1'b0;
      end else if (lo >= 0 && !dj && !dp) begin
        m_ent <= 1'b1;
        m_src <= lo;
      end
      m_pend <= pn | (irq & ~m_prev);
      m_mask <= mask_we ? mask_wd : m_mask;
      m_prev <= irq;
    end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {irq, mask_we, mask_wd, dj, dp, cis, rom_pc} = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++;
    if ({hold, jen, jdata, pen, pdata, active, src, pend} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp 0", {hold, jen, jdata, pen, pdata, active, src, pend});
    end
    nxt();
  endtask

  task automatic test_basic();
    mask_we = 1'b1; mask_wd = 4'b0001; nxt();
    mask_we = 1'b0; irq = 4'b0001; rom_pc = 11'h123; nxt();
    @(negedge clk);
    n_tests++;
    if ({hold, pend} !== 5'b0_0001) begin n_fail++; $display("FAIL basic_pend got %b exp 00001", {hold, pend}); end
    nxt();
    @(negedge clk);
    n_tests++;
    if ({hold, jen, pen, jdata, pdata, src} !== {3'b111, 11'h780, 11'h123, 3'd0}) begin
      n_fail++; $display("FAIL basic_entry got %b/%h/%h/%0d exp 111/780/123/0", {hold, jen, pen}, jdata, pdata, src);
    end
    nxt();
    irq = 4'b0000;
    @(negedge clk);
    n_tests++;
    if ({active, hold, pend} !== 6'b10_0000) begin n_fail++; $display("FAIL basic_active got %b exp 100000", {active, hold, pend}); end
    nxt();
    repeat (3) nxt();
    cis = 1'b1;
    @(negedge clk);
    n_tests++;
    if (active !== 1'b1) begin n_fail++; $display("FAIL basic_hold_active got %b exp 1", active); end
    nxt();
    cis = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({active, hold} !== 2'b00) begin n_fail++; $display("FAIL basic_cleared got %b exp 00", {active, hold}); end
    nxt();
  endtask

  task automatic test_priority();
    mask_we = 1'b1; mask_wd = 4'b1111; nxt();
    mask_we = 1'b0; irq = 4'b0110; nxt();
    @(negedge clk);
    n_tests++;
    if (pend !== 4'b0110) begin n_fail++; $display("FAIL prio_pend got %b exp 0110", pend); end
    nxt();
    irq = 4'b0000;
    @(negedge clk);
    n_tests++;
    if ({hold, jdata, src} !== {1'b1, 11'h788, 3'd1}) begin n_fail++; $display("FAIL prio_first got %b/%h/%0d exp 1/788/1", hold, jdata, src); end
    nxt();
    cis = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({active, pend} !== 5'b1_0100) begin n_fail++; $display("FAIL prio_active got %b exp 10100", {active, pend}); end
    nxt();
    cis = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({active, hold} !== 2'b00) begin n_fail++; $display("FAIL prio_idle got %b exp 00", {active, hold}); end
    nxt();
    @(negedge clk);
    n_tests++;
    if ({hold, jdata, src} !== {1'b1, 11'h790, 3'd2}) begin n_fail++; $display("FAIL prio_second got %b/%h/%0d exp 1/790/2", hold, jdata, src); end
    nxt();
    cis = 1'b1; nxt();
    cis = 1'b0; nxt();
  endtask

  task automatic test_dec_block();
    irq = 4'b0001; dj = 1'b1; nxt();
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin dj = 1'b0; dp = 1'b1; end
      if (c == 4) dp = 1'b0;
      @(negedge clk);
      n_tests++;
      if (hold !== 1'b0) begin n_fail++; $display("FAIL dec_block_c%0d got %b exp 0", c, hold); end
      nxt();
    end
    irq = 4'b0000;
    @(negedge clk);
    n_tests++;
    if ({hold, jdata} !== {1'b1, 11'h780}) begin n_fail++; $display("FAIL dec_entry got %b/%h exp 1/780", hold, jdata); end
    nxt();
    cis = 1'b1; nxt();
    cis = 1'b0;
    @(negedge clk);
    n_tests++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL dec_cleared got %b exp 0", active); end
    nxt();
  endtask

  task automatic test_masked();
    mask_we = 1'b1; mask_wd = 4'b0000; nxt();
    mask_we = 1'b0; irq = 4'b1000; nxt();
    irq = 4'b0000;
    @(negedge clk);
    n_tests++;
    if ({hold, pend} !== 5'b0_1000) begin n_fail++; $display("FAIL mask_pend got %b exp 01000", {hold, pend}); end
    nxt();
    nxt();
    mask_we = 1'b1; mask_wd = 4'b1000;
    @(negedge clk);
    n_tests++;
    if ({hold, pend} !== 5'b0_1000) begin n_fail++; $display("FAIL mask_persist got %b exp 01000", {hold, pend}); end
    nxt();
    mask_we = 1'b0;
    @(negedge clk);
    n_tests++;
    if (hold !== 1'b0) begin n_fail++; $display("FAIL mask_early got %b exp 0", hold); end
    nxt();
    @(negedge clk);
    n_tests++;
    if ({hold, jdata, src} !== {1'b1, 11'h798, 3'd3}) begin n_fail++; $display("FAIL mask_entry got %b/%h/%0d exp 1/798/3", hold, jdata, src); end
    nxt();
    cis = 1'b1; nxt();
    cis = 1'b0; nxt();
  endtask

  task automatic test_no_nest();
    mask_we = 1'b1; mask_wd = 4'b0001; irq = 4'b0001; nxt();
    mask_we = 1'b0; irq = 4'b0000; nxt();
    irq = 4'b0001;
    @(negedge clk);
    n_tests++;
    if ({hold, jdata} !== {1'b1, 11'h780}) begin n_fail++; $display("FAIL nest_entry got %b/%h exp 1/780", hold, jdata); end
    nxt();
    @(negedge clk);
    n_tests++;
    if ({active, pend} !== 5'b1_0001) begin n_fail++; $display("FAIL set_wins got %b exp 10001", {active, pend}); end
    nxt();
    irq = 4'b0000; nxt();
    irq = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({active, hold, pend} !== 6'b10_0001) begin n_fail++; $display("FAIL no_nest_c%0d got %b exp 100001", c, {active, hold, pend}); end
      nxt();
    end
    cis = 1'b1; nxt();
    cis = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({active, hold} !== 2'b00) begin n_fail++; $display("FAIL nest_idle got %b exp 00", {active, hold}); end
    nxt();
    @(negedge clk);
    n_tests++;
    if ({hold, jdata, src} !== {1'b1, 11'h780, 3'd0}) begin n_fail++; $display("FAIL reentry got %b/%h/%0d exp 1/780/0", hold, jdata, src); end
    nxt();
    cis = 1'b1; nxt();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if ({active, hold, pend} !== 6'b00_0000) begin n_fail++; $display("FAIL cis_idle_c%0d got %b exp 000000", c, {active, hold, pend}); end
      nxt();
    end
    cis = 1'b0;
  endtask

  task automatic test_reset_mid();
    irq = 4'b0000; nxt();
    irq = 4'b0001; nxt();
    nxt();
    @(negedge clk);
    n_tests++;
    if (hold !== 1'b1) begin n_fail++; $display("FAIL rmid_in_entry got %b exp 1", hold); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({hold, jen, jdata, pen, pdata, active, src, pend} !== '0) begin
      n_fail++; $display("FAIL rmid_outputs got %h exp 0", {hold, jen, jdata, pen, pdata, active, src, pend});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    nxt();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({hold, active, pend} !== 6'b00_0001) begin n_fail++; $display("FAIL rmid_mask_zero_c%0d got %b exp 000001", c, {hold, active, pend}); end
      nxt();
    end
    irq = 4'b0000;
  endtask

  task automatic test_random();
    logic [35:0] got, exp;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst_n = (c != 400);
      irq = irq ^ (4'($urandom) & 4'($urandom));
      mask_we = ($urandom_range(0, 5) == 0);
      mask_wd = 4'($urandom);
      dj = ($urandom_range(0, 3) == 0);
      dp = ($urandom_range(0, 7) == 0);
      cis = ($urandom_range(0, 4) == 0);
      rom_pc = 11'($urandom);
      @(negedge clk);
      got = {hold, jen, pen, jdata, pdata, active, src, pend};
      exp = {m_ent, m_ent, m_ent, m_ent ? 11'(11'h780 + 11'(m_src * 8)) : 11'h0,
             m_ent ? rom_pc : 11'h0, m_serv, 3'(m_src), m_pend};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL random_c%0d got %h exp %h", c, got, exp); end
      nxt();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_dec_block();
    test_masked();
    test_no_nest();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
